// File: rtl/modexp_pkg.sv
// Shared types and helpers for the Montgomery modular exponentiation engine.
package modexp_pkg;

  // Controller sequence: convert into Montgomery domain, walk the exponent, convert back.
  typedef enum logic [2:0] {
    IDLE,
    TO_MONT,
    LOOP,
    FROM_MONT,
    DONE
  } state_e;

  // Operand-select codes for the two multiplier input muxes.
  typedef enum logic [2:0] {
    OP_A,
    OP_R1,
    OP_XT,
    OP_X,
    OP_R2,
    OP_ONE
  } opsel_e;

  // Width needed to hold an exponent length in the range 0..exp_width.
  function automatic int modexp_len_w(input int exp_width);
    return $clog2(exp_width + 1);
  endfunction

endpackage

// File: rtl/modexp_engine_if.sv
// Host-side request/result bundle of the modular exponentiation engine.
interface modexp_engine_if
  import modexp_pkg::*;
#(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 1024,
  parameter int LEN_W     = modexp_len_w(EXP_WIDTH)
);

  logic                 start;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     modulus;
  logic [EXP_WIDTH-1:0] exponent;
  logic [LEN_W-1:0]     exp_len;
  logic [WIDTH-1:0]     Rmodm;
  logic [WIDTH-1:0]     Rsquaredmodm;
  logic                 busy;
  logic                 result_valid;
  logic                 result_ready;
  logic [WIDTH-1:0]     result;

  modport master (
    output start, x, modulus, exponent, exp_len, Rmodm, Rsquaredmodm, result_ready,
    input  busy, result_valid, result
  );

  modport slave (
    input  start, x, modulus, exponent, exp_len, Rmodm, Rsquaredmodm, result_ready,
    output busy, result_valid, result
  );

endinterface

// File: rtl/mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: p = a*b*2^-WIDTH mod m.
// Requires m odd and b < m; the result is fully reduced (< m).
// One start pulse, WIDTH accumulate cycles, one final-subtract cycle, then a done pulse.
module mont_mul #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] m_r;
  // Partial sum stays below 2m, and t + b + m below 4m, so two guard bits suffice.
  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] t_sum;
  logic [WIDTH+1:0] t_red;
  logic [CNT_W-1:0] cnt;
  logic             run;

  // One Montgomery step: add a_i*b, make the sum even by adding m, halve.
  always_comb begin
    t_sum = t + (a_sh[0] ? {2'b00, b_r} : '0);
    t_red = t_sum[0] ? (t_sum + {2'b00, m_r}) : t_sum;
  end

  // Sequencing: accept a start when idle, count WIDTH steps, pulse done on the final cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run  <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (!run) begin
        if (start) begin
          run <= 1'b1;
          cnt <= '0;
        end
      end else if (cnt == CNT_W'(WIDTH)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Operand capture, accumulation and final conditional subtraction.
  always_ff @(posedge clk) begin
    if (!run && start) begin
      a_sh <= a;
      b_r  <= b;
      m_r  <= m;
      t    <= '0;
    end else if (run) begin
      if (cnt != CNT_W'(WIDTH)) begin
        t    <= t_red >> 1;
        a_sh <= a_sh >> 1;
      end else begin
        p <= WIDTH'((t >= {2'b00, m_r}) ? (t - {2'b00, m_r}) : t);
      end
    end
  end

endmodule

// File: rtl/modexp_engine.sv
// Montgomery modular exponentiation controller: result = x^e mod m.
// Drives one shared mont_mul; LADDER selects square-and-multiply (0) or the
// constant-time Montgomery ladder (1). Result is held under a valid/ready handshake.
module modexp_engine
  import modexp_pkg::*;
#(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 1024,
  parameter int LADDER    = 0,
  parameter int LEN_W     = modexp_len_w(EXP_WIDTH)
) (
  input logic            clk,
  input logic            reset,
  modexp_engine_if.slave io
);

  state_e               state;
  state_e               state_nxt;
  logic [WIDTH-1:0]     x_r;
  logic [WIDTH-1:0]     m_r;
  logic [WIDTH-1:0]     r2_r;
  logic [WIDTH-1:0]     a_reg;   // A for square-and-multiply, R0 for the ladder
  logic [WIDTH-1:0]     r1_reg;
  logic [WIDTH-1:0]     xt_reg;
  logic [WIDTH-1:0]     result_r;
  logic [EXP_WIDTH-1:0] e_r;
  logic [LEN_W-1:0]     len_r;
  logic [LEN_W-1:0]     len_clamped;
  logic [LEN_W-1:0]     idx;
  logic                 phase;   // which of the (up to) two multiplies of the current bit
  logic                 mul_busy;
  logic                 mul_start;
  logic                 mul_done;
  logic                 cur_bit;
  logic                 bit_last;
  opsel_e               sel_a;
  opsel_e               sel_b;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [WIDTH-1:0]     mul_p;

  assign len_clamped = (io.exp_len > LEN_W'(EXP_WIDTH)) ? LEN_W'(EXP_WIDTH) : io.exp_len;
  assign cur_bit     = |(e_r & (EXP_WIDTH'(1) << idx));
  // Ladder always does two multiplies per bit; square-and-multiply skips the second on a 0 bit.
  assign bit_last    = (LADDER != 0) ? phase : (phase || !cur_bit);

  assign io.busy         = (state == TO_MONT) || (state == LOOP) || (state == FROM_MONT);
  assign io.result_valid = (state == DONE);
  assign io.result       = result_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, multiplier start pulse and operand selection.
  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    sel_a     = OP_A;
    sel_b     = OP_A;
    case (state)
      IDLE: begin
        if (io.start) state_nxt = TO_MONT;
      end
      TO_MONT: begin
        sel_a     = OP_X;
        sel_b     = OP_R2;
        mul_start = !mul_busy;
        if (mul_done) state_nxt = (len_r == '0) ? FROM_MONT : LOOP;
      end
      LOOP: begin
        mul_start = !mul_busy;
        if (LADDER != 0) begin
          if (!phase)       sel_b = OP_R1;
          else if (cur_bit) begin
            sel_a = OP_R1;
            sel_b = OP_R1;
          end
        end else if (phase) begin
          sel_b = OP_XT;
        end
        if (mul_done && bit_last && (idx == '0)) state_nxt = FROM_MONT;
      end
      FROM_MONT: begin
        sel_b     = OP_ONE;
        mul_start = !mul_busy;
        if (mul_done) state_nxt = DONE;
      end
      DONE: begin
        if (io.result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplier input muxes.
  always_comb begin
    op_a = a_reg;
    op_b = a_reg;
    case (sel_a)
      OP_X:    op_a = x_r;
      OP_R2:   op_a = r2_r;
      OP_R1:   op_a = r1_reg;
      OP_XT:   op_a = xt_reg;
      OP_ONE:  op_a = WIDTH'(1);
      default: op_a = a_reg;
    endcase
    case (sel_b)
      OP_X:    op_b = x_r;
      OP_R2:   op_b = r2_r;
      OP_R1:   op_b = r1_reg;
      OP_XT:   op_b = xt_reg;
      OP_ONE:  op_b = WIDTH'(1);
      default: op_b = a_reg;
    endcase
  end

  // Control: multiply-in-flight flag, bit counter, per-bit phase and the result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_busy <= 1'b0;
      idx      <= '0;
      phase    <= 1'b0;
      result_r <= '0;
    end else begin
      if (mul_start)     mul_busy <= 1'b1;
      else if (mul_done) mul_busy <= 1'b0;
      if (mul_done) begin
        case (state)
          TO_MONT: begin
            idx   <= len_r - LEN_W'(1);
            phase <= 1'b0;
          end
          LOOP: begin
            if (bit_last) begin
              phase <= 1'b0;
              if (idx != '0) idx <= idx - LEN_W'(1);
            end else begin
              phase <= 1'b1;
            end
          end
          FROM_MONT: result_r <= mul_p;
          default: ;
        endcase
      end
    end
  end

  // Operand capture at start and write-back of each product.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && io.start) begin
      x_r   <= io.x;
      m_r   <= io.modulus;
      e_r   <= io.exponent;
      len_r <= len_clamped;
      r2_r  <= io.Rsquaredmodm;
      a_reg <= io.Rmodm;
    end
    if (mul_done) begin
      case (state)
        TO_MONT: begin
          xt_reg <= mul_p;
          r1_reg <= mul_p;
        end
        LOOP: begin
          // Ladder destination: R0 gets the product exactly when phase differs from the bit.
          if ((LADDER == 0) || (phase ^ cur_bit)) a_reg  <= mul_p;
          else                                    r1_reg <= mul_p;
        end
        default: ;
      endcase
    end
  end

  mont_mul #(
    .WIDTH (WIDTH)
  ) u_mont_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (op_a),
    .b     (op_b),
    .m     (m_r),
    .done  (mul_done),
    .p     (mul_p)
  );

endmodule

// File: tb/tb_modexp_engine.sv
// Bench for modexp_engine: one square-and-multiply and one ladder instance driven in lockstep,
// results and multiply counts checked against a queued reference model.
module tb_modexp_engine;

  localparam int W  = 8;
  localparam int EW = 8;
  localparam int LW = 4;
  localparam int BUDGET = 4000;

  typedef struct {
    logic [W-1:0] res;
    int           mults;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   mc0 = 0, mc1 = 0, base0 = 0, base1 = 0;

  always #5 clk = ~clk;

  modexp_engine_if #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) if0 ();
  modexp_engine_if #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) if1 ();

  modexp_engine #(.WIDTH(W), .EXP_WIDTH(EW), .LADDER(0), .LEN_W(LW)) dut0 (
    .clk(clk), .reset(reset), .io(if0.slave));
  modexp_engine #(.WIDTH(W), .EXP_WIDTH(EW), .LADDER(1), .LEN_W(LW)) dut1 (
    .clk(clk), .reset(reset), .io(if1.slave));

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  // Reference: right-to-left binary exponentiation with plain integer arithmetic.
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [EW-1:0] e,
                                         input int len, input logic [W-1:0] m);
    longint r = 1, b = 0, mm = 0;
    mm = longint'(m);
    r  = 1 % mm;
    b  = longint'(x) % mm;
    for (int i = 0; i < len; i++) begin
      if (e[i]) r = (r * b) % mm;
      b = (b * b) % mm;
    end
    return W'(r);
  endfunction

  function automatic int popcnt(input logic [EW-1:0] e, input int len);
    int c = 0;
    for (int i = 0; i < len; i++) if (e[i]) c++;
    return c;
  endfunction

  // Count multiplier start pulses of each instance.
  always @(negedge clk) begin
    if (dut0.mul_start) mc0 <= mc0 + 1;
    if (dut1.mul_start) mc1 <= mc1 + 1;
  end

  // Result monitors: compare on each completed handshake.
  always @(negedge clk) begin
    exp_t ex;
    if (if0.result_valid && if0.result_ready) begin
      if (q0.size() == 0) check_val("dut0 unexpected result", 64'(if0.result_valid), 64'd0);
      else begin
        ex = q0.pop_front();
        check_val("dut0 result", 64'(if0.result), 64'(ex.res));
        check_val("dut0 mults", 64'(mc0 - base0), 64'(ex.mults));
        check_val("dut0 busy at valid", 64'(if0.busy), 64'd0);
      end
    end
    if (if1.result_valid && if1.result_ready) begin
      if (q1.size() == 0) check_val("dut1 unexpected result", 64'(if1.result_valid), 64'd0);
      else begin
        ex = q1.pop_front();
        check_val("dut1 result", 64'(if1.result), 64'(ex.res));
        check_val("dut1 mults", 64'(mc1 - base1), 64'(ex.mults));
        check_val("dut1 busy at valid", 64'(if1.busy), 64'd0);
      end
    end
  end

  task automatic drive(input logic s, input logic [W-1:0] x, input logic [EW-1:0] e,
                       input logic [LW-1:0] len, input logic [W-1:0] m);
    logic [W-1:0] rm, r2;
    rm = W'((longint'(1) << W) % longint'(m));
    r2 = W'((longint'(1) << (2 * W)) % longint'(m));
    if0.start = s; if0.x = x; if0.modulus = m; if0.exponent = e; if0.exp_len = len;
    if0.Rmodm = rm; if0.Rsquaredmodm = r2;
    if1.start = s; if1.x = x; if1.modulus = m; if1.exponent = e; if1.exp_len = len;
    if1.Rmodm = rm; if1.Rsquaredmodm = r2;
  endtask

  task automatic start_op(input logic [W-1:0] x, input logic [EW-1:0] e, input int len_in,
                          input logic [W-1:0] m);
    int   len;
    exp_t ex;
    len = (len_in > EW) ? EW : len_in;
    ex.res = model(x, e, len, m);
    ex.mults = 2 + len + popcnt(e, len);
    q0.push_back(ex);
    ex.mults = 2 + 2 * len;
    q1.push_back(ex);
    @(negedge clk);
    base0 = mc0;
    base1 = mc1;
    drive(1'b1, x, e, LW'(len_in), m);
    @(negedge clk);
    drive(1'b0, ~x, ~e, ~LW'(len_in), m ^ 8'h06);
  endtask

  task automatic wait_done(output int lat1);
    int guard;
    lat1 = 0;
    while (!if1.result_valid && lat1 < BUDGET) begin
      @(negedge clk);
      lat1++;
    end
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    check_val("op completes", 64'(q0.size() + q1.size()), 64'd0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [EW-1:0] e, input int len,
                        input logic [W-1:0] m, output int lat1);
    start_op(x, e, len, m);
    wait_done(lat1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, " busy0"},   64'(if0.busy), 64'd0);
    check_val({tag, " valid0"},  64'(if0.result_valid), 64'd0);
    check_val({tag, " result0"}, 64'(if0.result), 64'd0);
    check_val({tag, " busy1"},   64'(if1.busy), 64'd0);
    check_val({tag, " valid1"},  64'(if1.result_valid), 64'd0);
    check_val({tag, " result1"}, 64'(if1.result), 64'd0);
  endtask

  initial begin
    int           lat, lat_a, lat_b, guard;
    logic [W-1:0] m, x, stall_exp;
    logic [EW-1:0] e;

    reset = 1'b1;
    if0.result_ready = 1'b1;
    if1.result_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 4'd0, 8'hF1);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors: 2^10 mod 241 = 0x3C, empty exponent, single bit, clamped length.
    run_op(8'h02, 8'h0A, 4, 8'hF1, lat);
    run_op(8'h02, 8'h0A, 0, 8'hF1, lat);
    run_op(8'h02, 8'h01, 1, 8'hF1, lat);
    run_op(8'h05, 8'hFF, 12, 8'hF1, lat);
    run_op(8'hF0, 8'hAF, 8, 8'hF1, lat);

    // Random odd moduli, bases and exponents.
    for (int i = 0; i < 6; i++) begin
      m = W'($urandom_range(3, 255) | 1);
      x = W'($urandom_range(0, int'(m) - 1));
      e = EW'($urandom);
      run_op(x, e, $urandom_range(0, EW), m, lat);
    end

    // Ladder timing must not depend on exponent bits.
    run_op(8'h03, 8'h80, 8, 8'hF1, lat_a);
    run_op(8'h03, 8'hFF, 8, 8'hF1, lat_b);
    check_val("ladder constant time", 64'(lat_a), 64'(lat_b));

    // Backpressure: hold ready low, result must stay put and start pulses are ignored.
    if0.result_ready = 1'b0;
    if1.result_ready = 1'b0;
    stall_exp = model(8'h07, 8'h5B, 7, 8'hF1);
    start_op(8'h07, 8'h5B, 7, 8'hF1);
    guard = 0;
    while (!(if0.result_valid && if1.result_valid) && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    check_val("both valid under stall", 64'({if0.result_valid, if1.result_valid}), 64'h3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) drive(1'b1, 8'h09, 8'h33, 4'd5, 8'hF1);
      if (i == 6) drive(1'b0, 8'h09, 8'h33, 4'd5, 8'hF1);
      check_val("stall result0", 64'(if0.result), 64'(stall_exp));
      check_val("stall result1", 64'(if1.result), 64'(stall_exp));
      check_val("stall valid", 64'({if0.result_valid, if1.result_valid}), 64'h3);
      check_val("stall busy", 64'({if0.busy, if1.busy}), 64'h0);
    end
    // Release ready with start asserted in the handshake cycle: that start must be ignored.
    @(posedge clk);
    #1;
    if0.result_ready = 1'b1;
    if1.result_ready = 1'b1;
    drive(1'b1, 8'h09, 8'h33, 4'd5, 8'hF1);
    @(posedge clk);
    #1;
    drive(1'b0, 8'h09, 8'h33, 4'd5, 8'hF1);
    @(negedge clk);
    check_val("valid drops after handshake", 64'({if0.result_valid, if1.result_valid}), 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("handshake start ignored", 64'({if0.busy, if1.busy}), 64'h0);
    end
    check_val("stall queue drained", 64'(q0.size() + q1.size()), 64'd0);
    q0.delete();
    q1.delete();
    run_op(8'h09, 8'h33, 5, 8'hF1, lat);

    // Reset in the middle of the exponent loop, then a clean restart.
    start_op(8'h02, 8'hFF, 8, 8'hF1);
    repeat (60) @(negedge clk);
    check_val("busy mid loop", 64'({if0.busy, if1.busy}), 64'h3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("mid-op reset");
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(8'h02, 8'hFF, 8, 8'hF1, lat);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
